// File: rtl/uart_tx_ctrl.sv
// FIFO-buffered UART transmitter: 8N1 frames, bit timing paced by txclk_en.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 txclk_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [DATA_BITS-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_next;
  logic                 tx_reg;
  logic                 tx_next;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg;
  logic                 parity_next;
`endif

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign wr_ready = !full;
  // A full FIFO refuses the write even if a pop frees a slot on the same edge.
  assign push     = wr_valid && !full;
  assign head     = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    if (txclk_en) begin
      case (state_reg)
        // STOP shares IDLE's pop path so queued frames follow with no gap.
        ST_IDLE, ST_STOP: begin
          if (!empty) begin
            pop          = 1'b1;
            shift_next   = head;
            bit_cnt_next = '0;
            tx_next      = 1'b0;
            state_next   = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_next  = ^head;
`endif
          end else begin
            tx_next    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_START: begin
          tx_next    = shift_reg[0];
          state_next = ST_DATA;
        end
        ST_DATA: begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = ST_PARITY;
`else
            tx_next    = 1'b1;
            state_next = ST_STOP;
`endif
          end else begin
            tx_next = shift_reg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx_next    = 1'b1;
          state_next = ST_STOP;
        end
`endif
        default: begin
          tx_next    = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      count_reg   <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign tx         = tx_reg;
  assign busy       = (state_reg != ST_IDLE) || !empty;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised scoreboard bench for uart_tx_ctrl: a frame-level line model plus
// a decoupled monitor that decodes frames off tx and matches them to written bytes.
module tb_uart_tx_ctrl;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = DB + 2 + PAR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          txclk_en = 1'b0;
  logic [DB-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  uart_tx_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .txclk_en(txclk_en), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .tx(tx), .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bytes waiting in the FIFO, the byte on the line and how
  // many line bits of its frame remain (0 = line idle).
  logic [DB-1:0] mdl_q[$];
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] cur_byte = '0;
  int            frame_pos = 0;
  int            en_period = 4;
  int            en_ctr = 0;
  int            mon_frames = 0;

  logic prev_en = 1'b0;
  logic prev_rst = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic next_en();
    en_ctr++;
    if (en_period == 0) return 1'b0;
    if (en_period < 0) return ($urandom_range(0, 3) == 0);
    return (en_ctr % en_period) == 0;
  endfunction

  function automatic int exp_tx();
    int idx;
    if (frame_pos == 0) return 1;
    idx = FRAME_LEN - frame_pos;
    if (idx == 0) return 0;
    if (idx <= DB) return int'(cur_byte[idx-1]);
    if (PAR == 1 && idx == DB + 1) return int'(^cur_byte);
    return 1;
  endfunction

  // One clock: drive inputs, advance the model at the edge, check on the negedge.
  task automatic step(input logic rst, input logic v, input logic [DB-1:0] d, input logic e);
    logic acc;
    logic do_pop;
    reset    = rst;
    wr_valid = v;
    wr_data  = d;
    txclk_en = e;
    @(posedge clk);
    if (rst) begin
      mdl_q.delete();
      exp_q.delete();
      frame_pos = 0;
    end else begin
      acc    = v && (mdl_q.size() < DEPTH);
      do_pop = e && (frame_pos <= 1) && (mdl_q.size() > 0);
      if (e) begin
        if (do_pop) begin
          cur_byte  = mdl_q.pop_front();
          frame_pos = FRAME_LEN;
        end else if (frame_pos > 0) begin
          frame_pos--;
        end
      end
      if (acc) begin
        mdl_q.push_back(d);
        exp_q.push_back(d);
      end
    end
    @(negedge clk);
    check("fifo_count", int'(fifo_count), mdl_q.size());
    check("busy", int'(busy), int'(frame_pos != 0 || mdl_q.size() != 0));
    check("wr_ready", int'(wr_ready), int'(mdl_q.size() < DEPTH));
    check("tx", int'(tx), exp_tx());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, next_en());
  endtask

  task automatic write_byte(input logic [DB-1:0] d);
    step(1'b0, 1'b1, d, next_en());
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((frame_pos != 0 || mdl_q.size() != 0) && k < 3000) begin
      step(1'b0, 1'b0, '0, next_en());
      k++;
    end
    idle(3);
    check("drained_frames_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      prev_en  = txclk_en;
      prev_rst = reset;
    end
  end

  // Monitor: decodes frames from tx, one bit per strobe, and scores them.
  initial begin
    bit            mon_active;
    int            mon_idx;
    logic [DB-1:0] mon_byte;
    logic [DB-1:0] exp_b;
    logic          mon_par;
    mon_active = 1'b0;
    mon_idx    = 0;
    mon_byte   = '0;
    mon_par    = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        mon_active = 1'b0;
      end else if (prev_en) begin
        if (!mon_active) begin
          if (tx == 1'b0) begin
            mon_active = 1'b1;
            mon_idx    = 1;
            mon_byte   = '0;
          end
        end else begin
          if (mon_idx <= DB) mon_byte[mon_idx-1] = tx;
          else if (mon_idx == DB + 1 && mon_idx != FRAME_LEN - 1) mon_par = tx;
          if (mon_idx == FRAME_LEN - 1) begin
            mon_frames++;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame (t=%0t)", mon_byte, $time);
            end else begin
              exp_b = exp_q.pop_front();
              check("frame_data", int'(mon_byte), int'(exp_b));
              $display("frame %0d: byte 0x%02h expected 0x%02h", mon_frames, mon_byte, exp_b);
            end
            check("frame_stop", int'(tx), 1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", int'(mon_par), int'(^mon_byte));
`endif
            mon_active = 1'b0;
          end else begin
            mon_idx++;
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  frames_before;
    bit  hit;
    logic e;

    // Reset, then a long idle stretch.
    en_period = 4;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("reset_tx", int'(tx), 1);
    check("reset_count", int'(fifo_count), 0);
    idle(100);

    // Single 0xA5 with a strobe every 4 clocks.
    write_byte(8'hA5);
    drain();

    // Back-to-back frames written on consecutive clocks.
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h55);
    drain();

    // Overflow: no strobes, five writes, then release the line.
    en_period = 0;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    check("overflow_count", int'(fifo_count), DEPTH);
    check("overflow_ready", int'(wr_ready), 0);
    en_period = 2;
    drain();

    // Push on the same edge as the stop-strobe pop with two bytes queued.
    en_period = 0;
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    en_period = 4;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      e = next_en();
      if (e && frame_pos == 1 && mdl_q.size() == 2) begin
        check("pushpop_pre", int'(fifo_count), 2);
        step(1'b0, 1'b1, 8'($urandom), e);
        check("pushpop_count", int'(fifo_count), 2);
        hit = 1'b1;
      end else begin
        step(1'b0, 1'b0, '0, e);
      end
    end
    check("pushpop_reached", int'(hit), 1);
    drain();

    // Reset during data bit 3 of 0x3C with two more bytes queued.
    en_period = 0;
    write_byte(8'h3C);
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    en_period = 4;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      step(1'b0, 1'b0, '0, next_en());
      if (frame_pos == FRAME_LEN - 4) hit = 1'b1;
    end
    check("midframe_reached", int'(hit), 1);
    step(1'b1, 1'b0, '0, next_en());
    check("midframe_reset_tx", int'(tx), 1);
    check("midframe_reset_count", int'(fifo_count), 0);
    frames_before = mon_frames;
    idle(80);
    check("midframe_no_frames", mon_frames - frames_before, 0);

    // Strobe held high: one clock per bit.
    en_period = 1;
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    drain();

    // Random writes against random strobes.
    en_period = -1;
    for (int i = 0; i < 600; i++) begin
      step(1'b0, ($urandom_range(0, 2) == 0), 8'($urandom), next_en());
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
